// File: rtl/vid_timing_gen_cfg_if.sv
// rtl/vid_timing_gen_cfg_if.sv - configuration load bus for the video timing generator
interface vid_timing_gen_cfg_if #(
    parameter int CNT_W = 11
);
    logic             CFG_LOAD;
    logic [CNT_W-1:0] CFG_H_ACTIVE;
    logic [CNT_W-1:0] CFG_H_FP;
    logic [CNT_W-1:0] CFG_H_SYNC;
    logic [CNT_W-1:0] CFG_H_BP;
    logic [CNT_W-1:0] CFG_V_ACTIVE;
    logic [CNT_W-1:0] CFG_V_FP;
    logic [CNT_W-1:0] CFG_V_SYNC;
    logic [CNT_W-1:0] CFG_V_BP;
    logic             CFG_H_POL;
    logic             CFG_V_POL;
    logic             CFG_PENDING;
    logic             CFG_ERR;

    modport master (
        output CFG_LOAD, CFG_H_ACTIVE, CFG_H_FP, CFG_H_SYNC, CFG_H_BP,
               CFG_V_ACTIVE, CFG_V_FP, CFG_V_SYNC, CFG_V_BP, CFG_H_POL, CFG_V_POL,
        input  CFG_PENDING, CFG_ERR
    );

    modport slave (
        input  CFG_LOAD, CFG_H_ACTIVE, CFG_H_FP, CFG_H_SYNC, CFG_H_BP,
               CFG_V_ACTIVE, CFG_V_FP, CFG_V_SYNC, CFG_V_BP, CFG_H_POL, CFG_V_POL,
        output CFG_PENDING, CFG_ERR
    );
endinterface

// File: rtl/vid_timing_gen_cfg.sv
// rtl/vid_timing_gen_cfg.sv - run-time reconfigurable video timing generator with matched control delay
module vid_timing_gen_cfg #(
    parameter int   CNT_W        = 11,
    parameter int   CTRL_DELAY   = 3,
    parameter int   FRM_W        = 16,
    parameter int   DEF_H_ACTIVE = 1280,
    parameter int   DEF_H_FP     = 64,
    parameter int   DEF_H_SYNC   = 128,
    parameter int   DEF_H_BP     = 192,
    parameter logic DEF_H_POL    = 1'b0,
    parameter int   DEF_V_ACTIVE = 720,
    parameter int   DEF_V_FP     = 3,
    parameter int   DEF_V_SYNC   = 5,
    parameter int   DEF_V_BP     = 20,
    parameter logic DEF_V_POL    = 1'b0
) (
    input  logic                 CLK,
    input  logic                 nRST,
    vid_timing_gen_cfg_if.slave  cfg,
    output logic [CNT_W-1:0]     HCNT,
    output logic [CNT_W-1:0]     VCNT,
    output logic                 SOF,
    output logic                 EOL,
    output logic                 DE,
    output logic                 HSYNC,
    output logic                 VSYNC,
    output logic [FRM_W-1:0]     FRAME_CNT
);

    localparam int TW = CNT_W + 2;
    localparam logic [TW-1:0] TOT_MAX = TW'(1) << CNT_W;
    localparam logic [2:0] CTL_IDLE = {1'b0, ~DEF_H_POL, ~DEF_V_POL};

    typedef struct packed {
        logic [CNT_W-1:0] h_active;
        logic [CNT_W-1:0] h_fp;
        logic [CNT_W-1:0] h_sync;
        logic [CNT_W-1:0] h_bp;
        logic [CNT_W-1:0] v_active;
        logic [CNT_W-1:0] v_fp;
        logic [CNT_W-1:0] v_sync;
        logic [CNT_W-1:0] v_bp;
        logic             h_pol;
        logic             v_pol;
    } timing_t;

    localparam timing_t DEF_TIMING = '{
        h_active: CNT_W'(DEF_H_ACTIVE), h_fp: CNT_W'(DEF_H_FP),
        h_sync:   CNT_W'(DEF_H_SYNC),   h_bp: CNT_W'(DEF_H_BP),
        v_active: CNT_W'(DEF_V_ACTIVE), v_fp: CNT_W'(DEF_V_FP),
        v_sync:   CNT_W'(DEF_V_SYNC),   v_bp: CNT_W'(DEF_V_BP),
        h_pol:    DEF_H_POL,            v_pol: DEF_V_POL
    };

    function automatic logic [TW-1:0] sum4(input logic [CNT_W-1:0] a, b, c, d);
        return TW'(a) + TW'(b) + TW'(c) + TW'(d);
    endfunction

    timing_t          run_q;
    timing_t          pend_q;
    timing_t          req;
    logic             pending_q;
    logic             err_q;
    logic [CNT_W-1:0] hcnt_q;
    logic [CNT_W-1:0] vcnt_q;
    logic [FRM_W-1:0] frame_q;

    logic [TW-1:0] h_tot, v_tot, req_h_tot, req_v_tot;
    logic [TW-1:0] hc, vc, hs_start, vs_start;
    logic          h_last, v_last, frame_end, apply;
    logic          req_ok, load_ok, load_bad;
    logic          de_raw, hs_raw, vs_raw;
    logic [2:0]    ctl;

    assign req = '{
        h_active: cfg.CFG_H_ACTIVE, h_fp: cfg.CFG_H_FP,
        h_sync:   cfg.CFG_H_SYNC,   h_bp: cfg.CFG_H_BP,
        v_active: cfg.CFG_V_ACTIVE, v_fp: cfg.CFG_V_FP,
        v_sync:   cfg.CFG_V_SYNC,   v_bp: cfg.CFG_V_BP,
        h_pol:    cfg.CFG_H_POL,    v_pol: cfg.CFG_V_POL
    };

    assign req_h_tot = sum4(req.h_active, req.h_fp, req.h_sync, req.h_bp);
    assign req_v_tot = sum4(req.v_active, req.v_fp, req.v_sync, req.v_bp);
    assign req_ok    = (req.h_active != '0) && (req.h_sync != '0) &&
                       (req.v_active != '0) && (req.v_sync != '0) &&
                       (req_h_tot <= TOT_MAX) && (req_v_tot <= TOT_MAX);
    assign load_ok   = cfg.CFG_LOAD && req_ok;
    assign load_bad  = cfg.CFG_LOAD && !req_ok;

    assign h_tot     = sum4(run_q.h_active, run_q.h_fp, run_q.h_sync, run_q.h_bp);
    assign v_tot     = sum4(run_q.v_active, run_q.v_fp, run_q.v_sync, run_q.v_bp);
    assign hc        = TW'(hcnt_q);
    assign vc        = TW'(vcnt_q);
    assign h_last    = (hc == h_tot - TW'(1));
    assign v_last    = (vc == v_tot - TW'(1));
    assign frame_end = h_last && v_last;
    // The frame's last pixel is the only point where the running timing may change.
    assign apply     = frame_end && pending_q;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            run_q     <= DEF_TIMING;
            pend_q    <= DEF_TIMING;
            pending_q <= 1'b0;
            err_q     <= 1'b0;
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            frame_q   <= '0;
        end else begin
            err_q <= load_bad;
            if (apply) begin
                run_q <= pend_q;
            end
            if (load_ok) begin
                pend_q <= req;
            end
            // A load landing on the apply edge queues behind the one being applied.
            pending_q <= load_ok || (pending_q && !apply);
            if (h_last) begin
                hcnt_q <= '0;
                if (v_last) begin
                    vcnt_q  <= '0;
                    frame_q <= frame_q + FRM_W'(1);
                end else begin
                    vcnt_q <= vcnt_q + CNT_W'(1);
                end
            end else begin
                hcnt_q <= hcnt_q + CNT_W'(1);
            end
        end
    end

    assign hs_start = TW'(run_q.h_active) + TW'(run_q.h_fp);
    assign vs_start = TW'(run_q.v_active) + TW'(run_q.v_fp);
    assign de_raw   = (hc < TW'(run_q.h_active)) && (vc < TW'(run_q.v_active));
    assign hs_raw   = (hc >= hs_start) && (hc < hs_start + TW'(run_q.h_sync));
    assign vs_raw   = (vc >= vs_start) && (vc < vs_start + TW'(run_q.v_sync));
    assign ctl      = {de_raw, hs_raw ~^ run_q.h_pol, vs_raw ~^ run_q.v_pol};

    generate
        if (CTRL_DELAY == 0) begin : g_nodly
            assign {DE, HSYNC, VSYNC} = ctl;
        end else begin : g_dly
            logic [CTRL_DELAY-1:0][2:0] dly_q;
            always_ff @(posedge CLK) begin
                if (!nRST) begin
                    dly_q <= {CTRL_DELAY{CTL_IDLE}};
                end else begin
                    dly_q[0] <= ctl;
                    for (int i = 1; i < CTRL_DELAY; i++) begin
                        dly_q[i] <= dly_q[i-1];
                    end
                end
            end
            assign {DE, HSYNC, VSYNC} = dly_q[CTRL_DELAY-1];
        end
    endgenerate

    assign HCNT            = hcnt_q;
    assign VCNT            = vcnt_q;
    assign SOF             = (hcnt_q == '0) && (vcnt_q == '0);
    assign EOL             = h_last;
    assign FRAME_CNT       = frame_q;
    assign cfg.CFG_PENDING = pending_q;
    assign cfg.CFG_ERR     = err_q;

endmodule

// File: tb/tb_vid_timing_gen_cfg.sv
// tb/tb_vid_timing_gen_cfg.sv - self-checking bench for vid_timing_gen_cfg
module tb_vid_timing_gen_cfg;
    localparam int CW = 4;
    localparam int FW = 8;
    localparam int D_HA = 3, D_HF = 1, D_HS = 1, D_HB = 1;
    localparam int D_VA = 2, D_VF = 1, D_VS = 1, D_VB = 1;
    localparam bit D_HP = 1'b0, D_VP = 1'b0;

    typedef struct {
        int ha, hf, hsy, hb, va, vf, vsy, vb;
        bit hp, vp;
        bit exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic          ld;
    logic [CW-1:0] ha, hf, hsy, hb, va, vf, vsy, vb;
    logic          hp, vp;

    logic [CW-1:0] hcnt0, vcnt0, hcnt3, vcnt3;
    logic          sof0, eol0, de0, hs0, vs0, sof3, eol3, de3, hs3, vs3;
    logic [FW-1:0] fc0, fc3;

    vid_timing_gen_cfg_if #(.CNT_W(CW)) if0 ();
    vid_timing_gen_cfg_if #(.CNT_W(CW)) if3 ();

    assign if0.CFG_LOAD = ld;      assign if3.CFG_LOAD = ld;
    assign if0.CFG_H_ACTIVE = ha;  assign if3.CFG_H_ACTIVE = ha;
    assign if0.CFG_H_FP = hf;      assign if3.CFG_H_FP = hf;
    assign if0.CFG_H_SYNC = hsy;   assign if3.CFG_H_SYNC = hsy;
    assign if0.CFG_H_BP = hb;      assign if3.CFG_H_BP = hb;
    assign if0.CFG_V_ACTIVE = va;  assign if3.CFG_V_ACTIVE = va;
    assign if0.CFG_V_FP = vf;      assign if3.CFG_V_FP = vf;
    assign if0.CFG_V_SYNC = vsy;   assign if3.CFG_V_SYNC = vsy;
    assign if0.CFG_V_BP = vb;      assign if3.CFG_V_BP = vb;
    assign if0.CFG_H_POL = hp;     assign if3.CFG_H_POL = hp;
    assign if0.CFG_V_POL = vp;     assign if3.CFG_V_POL = vp;

    vid_timing_gen_cfg #(
        .CNT_W(CW), .CTRL_DELAY(0), .FRM_W(FW),
        .DEF_H_ACTIVE(D_HA), .DEF_H_FP(D_HF), .DEF_H_SYNC(D_HS), .DEF_H_BP(D_HB), .DEF_H_POL(D_HP),
        .DEF_V_ACTIVE(D_VA), .DEF_V_FP(D_VF), .DEF_V_SYNC(D_VS), .DEF_V_BP(D_VB), .DEF_V_POL(D_VP)
    ) dut0 (
        .CLK(clk), .nRST(rstn), .cfg(if0),
        .HCNT(hcnt0), .VCNT(vcnt0), .SOF(sof0), .EOL(eol0),
        .DE(de0), .HSYNC(hs0), .VSYNC(vs0), .FRAME_CNT(fc0)
    );

    vid_timing_gen_cfg #(
        .CNT_W(CW), .CTRL_DELAY(3), .FRM_W(FW),
        .DEF_H_ACTIVE(D_HA), .DEF_H_FP(D_HF), .DEF_H_SYNC(D_HS), .DEF_H_BP(D_HB), .DEF_H_POL(D_HP),
        .DEF_V_ACTIVE(D_VA), .DEF_V_FP(D_VF), .DEF_V_SYNC(D_VS), .DEF_V_BP(D_VB), .DEF_V_POL(D_VP)
    ) dut3 (
        .CLK(clk), .nRST(rstn), .cfg(if3),
        .HCNT(hcnt3), .VCNT(vcnt3), .SOF(sof3), .EOL(eol3),
        .DE(de3), .HSYNC(hs3), .VSYNC(vs3), .FRAME_CNT(fc3)
    );

    // Reference model: timing fields as plain integers, delay line as a queue.
    int       r[8], p[8];
    bit       rhp, rvp, php, pvp, pf, merr;
    int       mh, mv, mfc;
    bit [2:0] q3[$];
    int       errors = 0;
    int       checks = 0;

    function automatic int htot();
        return r[0] + r[1] + r[2] + r[3];
    endfunction

    function automatic int vtot();
        return r[4] + r[5] + r[6] + r[7];
    endfunction

    function automatic bit [2:0] raw_ctl();
        bit de, h_on, v_on;
        de   = (mh < r[0]) && (mv < r[4]);
        h_on = (mh >= r[0] + r[1]) && (mh < r[0] + r[1] + r[2]);
        v_on = (mv >= r[4] + r[5]) && (mv < r[4] + r[5] + r[6]);
        return {de, h_on == rhp, v_on == rvp};
    endfunction

    task automatic model_step();
        int       req[8];
        bit       ok, last;
        bit [2:0] pre;
        req = '{int'(ha), int'(hf), int'(hsy), int'(hb), int'(va), int'(vf), int'(vsy), int'(vb)};
        if (!rstn) begin
            r = '{D_HA, D_HF, D_HS, D_HB, D_VA, D_VF, D_VS, D_VB};
            rhp = D_HP; rvp = D_VP; pf = 0; merr = 0;
            mh = 0; mv = 0; mfc = 0;
            q3.delete();
            repeat (3) q3.push_back({1'b0, ~D_HP, ~D_VP});
            return;
        end
        ok = (req[0] != 0) && (req[2] != 0) && (req[4] != 0) && (req[6] != 0) &&
             (req[0] + req[1] + req[2] + req[3] <= (1 << CW)) &&
             (req[4] + req[5] + req[6] + req[7] <= (1 << CW));
        merr = ld && !ok;
        pre  = raw_ctl();
        last = (mh == htot() - 1) && (mv == vtot() - 1);
        if (mh == htot() - 1) begin
            mh = 0;
            if (mv == vtot() - 1) mv = 0;
            else mv++;
        end else begin
            mh++;
        end
        if (last) mfc = (mfc + 1) % (1 << FW);
        if (last && pf) begin
            r = p; rhp = php; rvp = pvp; pf = 0;
        end
        if (ld && ok) begin
            p = req; php = hp; pvp = vp; pf = 1;
        end
        q3.push_back(pre);
        void'(q3.pop_front());
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("hcnt0", int'(hcnt0), mh);
        check("hcnt3", int'(hcnt3), mh);
        check("vcnt0", int'(vcnt0), mv);
        check("vcnt3", int'(vcnt3), mv);
        check("sof0", int'(sof0), int'(mh == 0 && mv == 0));
        check("sof3", int'(sof3), int'(mh == 0 && mv == 0));
        check("eol0", int'(eol0), int'(mh == htot() - 1));
        check("eol3", int'(eol3), int'(mh == htot() - 1));
        check("ctl0", int'({de0, hs0, vs0}), int'(raw_ctl()));
        check("ctl3", int'({de3, hs3, vs3}), int'(q3[0]));
        check("pend0", int'(if0.CFG_PENDING), int'(pf));
        check("pend3", int'(if3.CFG_PENDING), int'(pf));
        check("err0", int'(if0.CFG_ERR), int'(merr));
        check("err3", int'(if3.CFG_ERR), int'(merr));
        check("frame0", int'(fc0), mfc);
        check("frame3", int'(fc3), mfc);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic load_vec(input vec_t c);
        ha = CW'(c.ha); hf = CW'(c.hf); hsy = CW'(c.hsy); hb = CW'(c.hb);
        va = CW'(c.va); vf = CW'(c.vf); vsy = CW'(c.vsy); vb = CW'(c.vb);
        hp = c.hp; vp = c.vp;
        ld = 1'b1;
        tick();
        ld = 1'b0;
    endtask

    task automatic wait_applied();
        for (int k = 0; k < 1000 && if0.CFG_PENDING; k++) tick();
        check("apply_wait", int'(if0.CFG_PENDING), 0);
    endtask

    task automatic frame_counts(input int ht, input int vt, input bit ehp, input bit evp,
                                output int n_de, output int n_hs, output int n_vs);
        n_de = 0; n_hs = 0; n_vs = 0;
        for (int k = 0; k < 400 && !sof0; k++) tick();
        check("sof_wait", int'(sof0), 1);
        for (int k = 0; k < ht * vt; k++) begin
            if (k > 0) tick();
            n_de += int'(de0);
            n_hs += int'(hs0 == ehp);
            n_vs += int'(vs0 == evp);
        end
    endtask

    vec_t vecs[7];

    initial begin
        int   n_de, n_hs, n_vs, ht, vt, n;
        vec_t a;

        vecs[0] = '{4, 1, 2, 1, 3, 1, 1, 1,  1'b1, 1'b1, 1'b0};
        vecs[1] = '{4, 1, 2, 1, 3, 1, 0, 1,  1'b1, 1'b1, 1'b1};
        vecs[2] = '{4, 1, 2, 10, 3, 1, 1, 1, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{0, 1, 2, 1, 3, 1, 1, 1,  1'b1, 1'b1, 1'b1};
        vecs[4] = '{8, 2, 4, 2, 3, 1, 1, 1,  1'b1, 1'b0, 1'b0};
        vecs[5] = '{4, 1, 2, 1, 10, 2, 3, 2, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{4, 1, 2, 1, 3, 1, 1, 1,  1'b0, 1'b0, 1'b0};

        ld = 1'b0; hp = 1'b0; vp = 1'b0;
        ha = '0; hf = '0; hsy = '0; hb = '0; va = '0; vf = '0; vsy = '0; vb = '0;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;

        // Delay line starts at the inactive level of the default polarities.
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            check("rst_idle_de3", int'(de3), 0);
            check("rst_idle_hs3", int'(hs3), 1);
            check("rst_idle_vs3", int'(vs3), 1);
        end

        foreach (vecs[i]) begin
            load_vec(vecs[i]);
            check("vec_err", int'(if0.CFG_ERR), int'(vecs[i].exp_err));
            check("vec_pend", int'(if0.CFG_PENDING), int'(!vecs[i].exp_err));
            tick();
            check("err_single", int'(if0.CFG_ERR), 0);
            if (!vecs[i].exp_err) begin
                wait_applied();
                ht = vecs[i].ha + vecs[i].hf + vecs[i].hsy + vecs[i].hb;
                vt = vecs[i].va + vecs[i].vf + vecs[i].vsy + vecs[i].vb;
                frame_counts(ht, vt, vecs[i].hp, vecs[i].vp, n_de, n_hs, n_vs);
                check("vec_de_count", n_de, vecs[i].ha * vecs[i].va);
                check("vec_hs_count", n_hs, vecs[i].hsy * vt);
                check("vec_vs_count", n_vs, vecs[i].vsy * ht);
            end
        end

        // Last load wins; a load on the apply edge stays pending for the next frame.
        a = vecs[0];
        load_vec(a);
        a.ha = 6;
        load_vec(a);
        for (int k = 0; k < 400 && !(mh == htot() - 1 && mv == vtot() - 1); k++) tick();
        a.ha = 8;
        load_vec(a);
        check("llw_pend", int'(if0.CFG_PENDING), 1);
        check("llw_sof", int'(sof0), 1);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) tick();
            n += int'(de0);
        end
        check("llw_line_de6", n, 6);
        wait_applied();
        n = 0;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) tick();
            n += int'(de0);
        end
        check("llw_line_de8", n, 8);

        // Reset mid-line with a config pending.
        load_vec(vecs[4]);
        tick();
        tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("rst_pend", int'(if0.CFG_PENDING), 0);
        check("rst_hcnt", int'(hcnt0), 0);
        check("rst_vcnt", int'(vcnt0), 0);
        check("rst_frame", int'(fc0), 0);
        frame_counts(6, 5, D_HP, D_VP, n_de, n_hs, n_vs);
        check("def_de_count", n_de, 6);
        check("def_hs_count", n_hs, 5);
        check("def_vs_count", n_vs, 6);

        // Frame counter wrap using the smallest legal frame.
        a = '{1, 0, 1, 0, 1, 0, 1, 0, 1'b1, 1'b1, 1'b0};
        load_vec(a);
        wait_applied();
        for (int k = 0; k < 3000 && fc0 != FW'(255); k++) tick();
        check("fc_reach_max", int'(fc0), 255);
        for (int k = 0; k < 8 && fc0 == FW'(255); k++) tick();
        check("fc_wrap", int'(fc0), 0);

        // Random loads (some illegal) and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                rstn = 1'b0;
                tick();
                rstn = 1'b1;
            end else if ($urandom_range(0, 15) == 0) begin
                ha = CW'($urandom_range(0, 6)); hf = CW'($urandom_range(0, 6));
                hsy = CW'($urandom_range(0, 6)); hb = CW'($urandom_range(0, 6));
                va = CW'($urandom_range(0, 6)); vf = CW'($urandom_range(0, 6));
                vsy = CW'($urandom_range(0, 6)); vb = CW'($urandom_range(0, 6));
                hp = 1'($urandom_range(0, 1)); vp = 1'($urandom_range(0, 1));
                ld = 1'b1;
                tick();
                ld = 1'b0;
            end else begin
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
